// File: rtl/rx_buffer_controller_pkg.sv
// Shared types and constants for the UART-style receive buffer controller.
// The RX_TIMEOUT_EN macro enables the character-timeout counter in the top level.
package rx_buffer_controller_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } rx_state_t;

  localparam logic [15:0] RBR_ADDR_DEF = 16'h0000;
  localparam logic [15:0] LSR_ADDR_DEF = 16'h0005;

  localparam int LSR_DR = 0;
  localparam int LSR_OE = 1;
  localparam int LSR_FE = 3;
  localparam int LSR_TO = 5;

  function automatic logic [7:0] lsr_pack(input logic dr, input logic oe,
                                          input logic fe, input logic to);
    logic [7:0] s;
    s         = 8'h00;
    s[LSR_DR] = dr;
    s[LSR_OE] = oe;
    s[LSR_FE] = fe;
    s[LSR_TO] = to;
    return s;
  endfunction

endpackage

// File: rtl/rx_buffer_mem.sv
// Receive byte storage: DEPTH x 8 registers, synchronous write, combinational read.
// Contents are intentionally not reset; the pointers alone define validity.
module rx_buffer_mem #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_buffer_controller.sv
// Receive FIFO controller with RBR/LSR bus reads and sticky overrun/framing flags.
// Define RX_TIMEOUT_EN to build the character-timeout counter; otherwise timeout is 0.
module rx_buffer_controller
  import rx_buffer_controller_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter logic [15:0] RBR_ADDR    = RBR_ADDR_DEF,
  parameter logic [15:0] LSR_ADDR    = LSR_ADDR_DEF,
  parameter logic [15:0] TIMEOUT_CYC = 16'd1024
) (
  input  logic                     m_clk,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic                     rx_frame_err,
  input  logic                     rd_en,
  input  logic [15:0]              address,
  output logic [7:0]               data_out_reg,
  output logic                     data_ready,
  output logic                     overrun,
  output logic                     frame_err,
  output logic                     timeout,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  rx_state_t     state, state_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_nxt;
  logic [7:0]    head, dout_nxt;
  logic          rbr_rd, lsr_rd, push, pop, ovr_set, fe_set;

  assign rbr_rd = rd_en && (address == RBR_ADDR);
  assign lsr_rd = rd_en && (address == LSR_ADDR) && !rbr_rd;
  assign pop    = rbr_rd && (state != EMPTY);
  // A simultaneous pop frees the slot, so a write while FULL still lands.
  assign push    = rx_valid && ((state != FULL) || pop);
  assign ovr_set = rx_valid && !push;
  assign fe_set  = rx_valid && rx_frame_err;

  assign data_ready = (level != '0);

  rx_buffer_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (m_clk),
    .we    (push && reset),
    .waddr (wr_ptr),
    .wdata (rx_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_comb begin
    level_nxt = level;
    state_nxt = state;
    dout_nxt  = data_out_reg;
    case ({push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
    if (level_nxt == '0)            state_nxt = EMPTY;
    else if (level_nxt == FULL_LVL) state_nxt = FULL;
    else                            state_nxt = PARTIAL;
    if (rbr_rd)      dout_nxt = pop ? head : 8'h00;
    else if (lsr_rd) dout_nxt = lsr_pack(data_ready, overrun, frame_err, timeout);
  end

  always_ff @(posedge m_clk) begin
    if (!reset) begin
      state        <= EMPTY;
      level        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      data_out_reg <= 8'h00;
      overrun      <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_nxt;
      level        <= level_nxt;
      data_out_reg <= dout_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // Set events win over an LSR clear in the same cycle.
      overrun   <= ovr_set || (overrun && !lsr_rd);
      frame_err <= fe_set || (frame_err && !lsr_rd);
    end
  end

`ifdef RX_TIMEOUT_EN
  logic [15:0] to_cnt, to_cnt_nxt;
  logic        to_nxt;

  always_comb begin
    to_cnt_nxt = to_cnt;
    to_nxt     = timeout;
    if (rx_valid || rbr_rd || state == EMPTY) to_cnt_nxt = '0;
    else if (to_cnt != TIMEOUT_CYC)           to_cnt_nxt = to_cnt + 16'd1;
    if (rbr_rd || level_nxt == '0)      to_nxt = 1'b0;
    else if (to_cnt_nxt == TIMEOUT_CYC) to_nxt = 1'b1;
  end

  always_ff @(posedge m_clk) begin
    if (!reset) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      to_cnt  <= to_cnt_nxt;
      timeout <= to_nxt;
    end
  end
`else
  // Constant 0; TIMEOUT_CYC is referenced so both builds share one parameter list.
  assign timeout = (TIMEOUT_CYC == 16'd0) && 1'b0;
`endif

endmodule

// File: tb/tb_rx_buffer_controller.sv
// Self-checking bench for rx_buffer_controller: vector table plus corner-case sequences.
module tb_rx_buffer_controller;

  localparam int          DEPTH = 4;
  localparam logic [15:0] RBR   = 16'h0000;
  localparam logic [15:0] LSR   = 16'h0005;
  localparam logic [15:0] OTHER = 16'h0003;

  logic        m_clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_frame_err = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [7:0]  data_out_reg;
  logic        data_ready, overrun, frame_err, timeout;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        fe;
    logic        rd;
    logic [15:0] a;
    logic [2:0]  lvl;
    logic        ovr;
    logic        fer;
    logic [7:0]  dout;
  } vec_t;

  vec_t vec[19];

  rx_buffer_controller #(
    .DEPTH(DEPTH), .RBR_ADDR(RBR), .LSR_ADDR(LSR), .TIMEOUT_CYC(16'd16)
  ) dut (
    .m_clk(m_clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_frame_err(rx_frame_err), .rd_en(rd_en), .address(address),
    .data_out_reg(data_out_reg), .data_ready(data_ready), .overrun(overrun),
    .frame_err(frame_err), .timeout(timeout), .level(level)
  );

  always #5 m_clk = ~m_clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic fe,
                              input logic rd, input logic [15:0] a, input logic [2:0] lvl,
                              input logic ovr, input logic fer, input logic [7:0] dout);
    vec_t r;
    r.v = v; r.d = d; r.fe = fe; r.rd = rd; r.a = a;
    r.lvl = lvl; r.ovr = ovr; r.fer = fer; r.dout = dout;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic fe,
                       input logic rd, input logic [15:0] a);
    rx_valid = v; rx_data = d; rx_frame_err = fe; rd_en = rd; address = a;
  endtask

  task automatic tick();
    @(posedge m_clk);
    #1;
    rx_valid = 1'b0; rx_frame_err = 1'b0; rd_en = 1'b0;
  endtask

  task automatic chk_dout(input string name);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s actual %0h required scoreboard entry", name, data_out_reg);
    end else begin
      e = exp_q.pop_front();
      chk(name, {24'd0, data_out_reg}, {24'd0, e});
    end
  endtask

  task automatic wr(input logic [7:0] d, input logic fe);
    drive(1'b1, d, fe, 1'b0, RBR);
    tick();
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string name);
    exp_q.push_back(exp);
    drive(1'b0, 8'h00, 1'b0, 1'b1, a);
    tick();
    chk_dout(name);
  endtask

  initial begin
    // basic flow, overrun, LSR and framing vectors
    vec[0]  = mk(1, 8'hA5, 0, 0, RBR,   1, 0, 0, 8'h00);
    vec[1]  = mk(1, 8'h3C, 0, 0, RBR,   2, 0, 0, 8'h00);
    vec[2]  = mk(0, 8'h00, 0, 1, RBR,   1, 0, 0, 8'hA5);
    vec[3]  = mk(0, 8'h00, 0, 1, RBR,   0, 0, 0, 8'h3C);
    vec[4]  = mk(0, 8'h00, 0, 1, RBR,   0, 0, 0, 8'h00);
    vec[5]  = mk(1, 8'h01, 0, 0, RBR,   1, 0, 0, 8'h00);
    vec[6]  = mk(1, 8'h02, 0, 0, RBR,   2, 0, 0, 8'h00);
    vec[7]  = mk(1, 8'h03, 0, 0, RBR,   3, 0, 0, 8'h00);
    vec[8]  = mk(1, 8'h04, 0, 0, RBR,   4, 0, 0, 8'h00);
    vec[9]  = mk(1, 8'h05, 0, 0, RBR,   4, 1, 0, 8'h00);
    vec[10] = mk(0, 8'h00, 0, 1, LSR,   4, 0, 0, 8'h03);
    vec[11] = mk(0, 8'h00, 0, 1, RBR,   3, 0, 0, 8'h01);
    vec[12] = mk(0, 8'h00, 0, 1, RBR,   2, 0, 0, 8'h02);
    vec[13] = mk(0, 8'h00, 0, 1, RBR,   1, 0, 0, 8'h03);
    vec[14] = mk(0, 8'h00, 0, 1, RBR,   0, 0, 0, 8'h04);
    vec[15] = mk(1, 8'h55, 1, 0, RBR,   1, 0, 1, 8'h04);
    vec[16] = mk(0, 8'h00, 0, 1, LSR,   1, 0, 0, 8'h09);
    vec[17] = mk(0, 8'h00, 0, 1, RBR,   0, 0, 0, 8'h55);
    vec[18] = mk(0, 8'h00, 0, 1, OTHER, 0, 0, 0, 8'h55);

    // reset state
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    chk("rst level", {29'd0, level}, 0);
    chk("rst dout", {24'd0, data_out_reg}, 0);
    chk("rst flags", {28'd0, data_ready, overrun, frame_err, timeout}, 0);

    foreach (vec[i]) begin
      drive(vec[i].v, vec[i].d, vec[i].fe, vec[i].rd, vec[i].a);
      if (vec[i].rd) exp_q.push_back(vec[i].dout);
      tick();
      if (vec[i].rd) chk_dout($sformatf("vec%0d dout", i));
      chk($sformatf("vec%0d level", i), {29'd0, level}, {29'd0, vec[i].lvl});
      chk($sformatf("vec%0d data_ready", i), {31'd0, data_ready}, {31'd0, vec[i].lvl != 3'd0});
      chk($sformatf("vec%0d overrun", i), {31'd0, overrun}, {31'd0, vec[i].ovr});
      chk($sformatf("vec%0d frame_err", i), {31'd0, frame_err}, {31'd0, vec[i].fer});
    end

    // overrun set beats LSR clear in the same cycle
    for (int i = 0; i < 4; i++) wr(8'h20 + 8'(i), 1'b0);
    exp_q.push_back(8'h01);
    drive(1'b1, 8'h24, 1'b0, 1'b1, LSR);
    tick();
    chk_dout("ovr prio lsr");
    chk("ovr prio flag", {31'd0, overrun}, 1);
    chk("ovr prio level", {29'd0, level}, 4);
    rd(LSR, 8'h03, "ovr lsr2");
    chk("ovr cleared", {31'd0, overrun}, 0);
    for (int i = 0; i < 4; i++) rd(RBR, 8'h20 + 8'(i), $sformatf("ovr drain%0d", i));

    // frame error set beats LSR clear in the same cycle
    wr(8'h30, 1'b1);
    exp_q.push_back(8'h09);
    drive(1'b1, 8'h31, 1'b1, 1'b1, LSR);
    tick();
    chk_dout("fe prio lsr");
    chk("fe prio flag", {31'd0, frame_err}, 1);
    chk("fe prio level", {29'd0, level}, 2);
    rd(LSR, 8'h09, "fe lsr2");
    chk("fe cleared", {31'd0, frame_err}, 0);
    rd(RBR, 8'h30, "fe drain0");
    rd(RBR, 8'h31, "fe drain1");

    // write and read together while FULL
    for (int i = 0; i < 4; i++) wr(8'h10 + 8'(i), 1'b0);
    exp_q.push_back(8'h10);
    drive(1'b1, 8'h77, 1'b0, 1'b1, RBR);
    tick();
    chk_dout("full rw dout");
    chk("full rw overrun", {31'd0, overrun}, 0);
    chk("full rw level", {29'd0, level}, 4);
    rd(RBR, 8'h11, "full rw r1");
    rd(RBR, 8'h12, "full rw r2");
    rd(RBR, 8'h13, "full rw r3");
    rd(RBR, 8'h77, "full rw r4");
    chk("full rw empty", {31'd0, data_ready}, 0);

    // character timeout
    wr(8'h42, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      tick();
`ifdef RX_TIMEOUT_EN
      chk($sformatf("timeout idle%0d", i), {31'd0, timeout}, {31'd0, i >= 16});
`else
      chk($sformatf("timeout idle%0d", i), {31'd0, timeout}, 0);
`endif
    end
    rd(RBR, 8'h42, "timeout rbr");
    chk("timeout cleared", {31'd0, timeout}, 0);

    // reset mid-operation with concurrent traffic
    wr(8'hE1, 1'b1);
    wr(8'hE2, 1'b0);
    wr(8'hE3, 1'b0);
    chk("pre-rst level", {29'd0, level}, 3);
    drive(1'b1, 8'h99, 1'b1, 1'b1, RBR);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst level", {29'd0, level}, 0);
    chk("midrst dout", {24'd0, data_out_reg}, 0);
    chk("midrst flags", {28'd0, data_ready, overrun, frame_err, timeout}, 0);
    rd(RBR, 8'h00, "midrst rbr");
    chk("midrst level2", {29'd0, level}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
